// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
//
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over XLEN
// CALC cycles, followed by one FIX cycle that applies the sign correction and
// writes HI/LO. Signed ops run on operand magnitudes.
//
// Optional build macro: MULDIV_FASTZERO_EN
//   When defined, a request with a zero operand skips CALC and completes two
//   edges after acceptance.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake from execute
//   req_op                00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   req_a, req_b          rs / rt operands
//   flush                 cancel the in-flight op, block same-cycle acceptance
//   hi_we/hi_wdata        MTHI write (ignored while busy)
//   lo_we/lo_wdata        MTLO write (ignored while busy)
//   busy                  op in flight
//   done                  one-cycle pulse, new HI/LO visible
//   hi, lo                architectural HI/LO
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic [XLEN-1:0] hi_wdata,
  input  logic            lo_we,
  input  logic [XLEN-1:0] lo_wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic            is_div_q, is_signed_q, neg_a_q, neg_b_q;
  logic [XLEN-1:0] a_orig_q;   // raw dividend, returned in HI on divide by zero
  logic [XLEN-1:0] opnd_q;     // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0] acc_hi_q;   // product high half / partial remainder
  logic [XLEN-1:0] acc_lo_q;   // multiplier bits / dividend-quotient shifter
  logic [XLEN-1:0] hi_q, lo_q;
  logic            done_q;

  // Request decode
  logic            accept, op_signed, op_div, zero_op;
  logic [XLEN-1:0] mag_a, mag_b;

  assign accept    = (state_q == S_IDLE) && req_valid && !flush;
  assign op_signed = !req_op[0];
  assign op_div    = req_op[1];
  assign zero_op   = (req_a == {XLEN{1'b0}}) || (req_b == {XLEN{1'b0}});
  assign mag_a     = (op_signed && req_a[XLEN-1]) ? -req_a : req_a;
  assign mag_b     = (op_signed && req_b[XLEN-1]) ? -req_b : req_b;

`ifdef MULDIV_FASTZERO_EN
  // The fast path spends two cycles in FIX so done lands two edges after acceptance.
  logic fix_hold_q;
  logic fix_last;
  assign fix_last = !fix_hold_q;
`else
  logic fix_last;
  assign fix_last = 1'b1;
`endif

  // One iteration step
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_trial;

  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : {XLEN{1'b0}})};
  assign div_trial = {acc_hi_q, acc_lo_q[XLEN-1]} - {1'b0, opnd_q};

  // Sign correction and special cases
  logic [2*XLEN-1:0] prod_mag, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_hi, res_lo;
  logic              signs_differ;

  always_comb begin
    signs_differ = is_signed_q && (neg_a_q ^ neg_b_q);
    prod_mag     = {acc_hi_q, acc_lo_q};
    prod_fix     = signs_differ ? -prod_mag : prod_mag;
    quo_fix      = signs_differ ? -acc_lo_q : acc_lo_q;
    rem_fix      = (is_signed_q && neg_a_q) ? -acc_hi_q : acc_hi_q;
    res_hi       = prod_fix[2*XLEN-1:XLEN];
    res_lo       = prod_fix[XLEN-1:0];
    if (is_div_q) begin
      if (opnd_q == {XLEN{1'b0}}) begin
        res_hi = a_orig_q;
        res_lo = {XLEN{1'b1}};
      end else begin
        // Most-negative / -1 falls out naturally: magnitude quotient 2^(XLEN-1),
        // signs equal so no negation, remainder zero.
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef MULDIV_FASTZERO_EN
          state_d = zero_op ? S_FIX : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (flush)                             state_d = S_IDLE;
        else if (cnt_q == CW'(XLEN - 1))       state_d = S_FIX;
      end
      S_FIX: begin
        if (flush || fix_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      a_orig_q    <= '0;
      opnd_q      <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
`ifdef MULDIV_FASTZERO_EN
      fix_hold_q  <= 1'b0;
`endif
    end else begin
      done_q <= (state_q == S_FIX) && !flush && fix_last;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= hi_wdata;
          if (lo_we) lo_q <= lo_wdata;
          if (accept) begin
            cnt_q       <= '0;
            is_div_q    <= op_div;
            is_signed_q <= op_signed;
            neg_a_q     <= op_signed && req_a[XLEN-1];
            neg_b_q     <= op_signed && req_b[XLEN-1];
            a_orig_q    <= req_a;
            acc_hi_q    <= '0;
            if (op_div) begin
              opnd_q   <= mag_b;
              acc_lo_q <= mag_a;
            end else begin
              opnd_q   <= mag_a;
              acc_lo_q <= mag_b;
            end
`ifdef MULDIV_FASTZERO_EN
            fix_hold_q <= zero_op;
            // Skipping CALC leaves the multiplier unshifted; clear it so the product reads zero.
            if (zero_op && !op_div) acc_lo_q <= '0;
`endif
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) begin
            if (!div_trial[XLEN]) begin
              acc_hi_q <= div_trial[XLEN-1:0];
              acc_lo_q <= {acc_lo_q[XLEN-2:0], 1'b1};
            end else begin
              acc_hi_q <= {acc_hi_q[XLEN-2:0], acc_lo_q[XLEN-1]};
              acc_lo_q <= {acc_lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_hi_q <= mul_sum[XLEN:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[XLEN-1:1]};
          end
        end
        S_FIX: begin
`ifdef MULDIV_FASTZERO_EN
          fix_hold_q <= 1'b0;
`endif
          if (!flush && fix_last) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign req_ready = !busy;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized self-checking bench for muldiv_seq with a behavioural model
module tb_muldiv_seq;

  localparam int XLEN = 32;
`ifdef MULDIV_FASTZERO_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] hi_wdata = '0, lo_wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we), .lo_wdata(lo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: begin sp = sa * sb; return sp; end
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int op_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTZERO_EN
    if (a == 32'd0 || b == 32'd0) return 2;
`endif
    return XLEN + 1;
  endfunction

  // Behavioural model: an op in flight is just a countdown of edges to completion
  logic [31:0] m_hi = '0, m_lo = '0, m_res_hi = '0, m_res_lo = '0;
  int          m_rem = 0;
  logic        m_done = 1'b0, m_nd;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0; m_live = 1'b1;
    end else begin
      m_nd = 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = m_res_hi; m_lo = m_res_lo; m_nd = 1'b1;
          end
        end
      end else begin
        if (hi_we) m_hi = hi_wdata;
        if (lo_we) m_lo = lo_wdata;
        if (req_valid && !flush) begin
          {m_res_hi, m_res_lo} = ref_result(req_op, req_a, req_b);
          m_rem = op_latency(req_a, req_b);
        end
      end
      m_done = m_nd;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", busy, m_rem > 0);
      chk("req_ready", req_ready, m_rem == 0);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    req_valid = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!req_ready && n < 60) begin tick(); n++; end
    chk("wait_ready", req_ready, 1'b1);
  endtask

  // Returns edges from acceptance to done (-1 if none within the bound) and busy cycles seen
  task automatic wait_done(output int edges, output int nb);
    edges = -1;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin edges = i; break; end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_edges);
    int e, nb;
    tick();
    wait_ready();
    issue(op, a, b);
    wait_done(e, nb);
    chk({name, "_edges"}, e, exp_edges);
    chk({name, "_busy_cycles"}, nb, exp_edges);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int e, nb;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_done", done, 1'b0);

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu_zero", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, ZLAT);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    run_op("divu_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    // Flush mid-CALC keeps prior HI/LO and produces no done
    tick();
    hi_we = 1'b1; hi_wdata = 32'h1234_5678; lo_we = 1'b1; lo_wdata = 32'h1234_5678;
    tick();
    clear_inputs();
    issue(2'd3, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 1'b0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'h1234_5678);
    wait_done(e, nb);
    chk("flush_no_done", e, -1);

    // MTHI while busy is dropped; MTLO plus a new request in the done cycle
    tick();
    issue(2'd1, 32'd3, 32'd5);
    repeat (3) tick();
    hi_we = 1'b1; hi_wdata = 32'h0000_AAAA;
    tick();
    hi_we = 1'b0;
    wait_done(e, nb);
    chk("busywr_done", e >= 0, 1'b1);
    chk("busywr_hi", hi, 32'd0);
    chk("busywr_lo", lo, 32'd15);
    lo_we = 1'b1; lo_wdata = 32'h55;
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd2; req_b = 32'd2;
    tick();
    clear_inputs();
    @(negedge clk);
    chk("b2b_lo", lo, 32'h55);
    chk("b2b_busy", busy, 1'b1);
    wait_done(e, nb);
    chk("b2b_result_lo", lo, 32'd4);
    chk("b2b_result_hi", hi, 32'd0);

    run_op("mult_zero", 2'd0, 32'd0, 32'd9, 32'd0, 32'd0, ZLAT);

    // Randomized traffic against the model
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 499) == 0);
      req_valid = $urandom_range(0, 1);
      req_op    = 2'($urandom_range(0, 3));
      req_a     = pick_operand();
      req_b     = pick_operand();
      flush     = ($urandom_range(0, 99) == 0);
      hi_we     = ($urandom_range(0, 15) == 0);
      lo_we     = ($urandom_range(0, 15) == 0);
      hi_wdata  = $urandom;
      lo_wdata  = $urandom;
      tick();
    end
    reset = 1'b0;
    clear_inputs();
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the architectural HI/LO registers.
- Sits beside the execute stage and is sequential: radix-2 shift-add multiply, restoring divide, one bit per cycle.
- Decode reads `hi`/`lo` for MFHI/MFLO and uses `busy` to stall.
- MTHI/MTLO writes also land here.

Parameters:
- XLEN, 32, operand width; HI/LO each XLEN bits; iteration count = XLEN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  1  execute presents a mul/div op
- req_ready  out  1  block can accept a request this cycle
- req_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- req_a  in  XLEN  rs operand (multiplicand / dividend)
- req_b  in  XLEN  rt operand (multiplier / divisor)
- flush  in  1  cancel in-flight op (exception/redirect)
- hi_we  in  1  MTHI write enable
- hi_wdata  in  XLEN  MTHI data
- lo_we  in  1  MTLO write enable
- lo_wdata  in  XLEN  MTLO data
- busy  out  1  op in flight; HI/LO not yet final
- done  out  1  one-cycle pulse: new HI/LO visible this cycle
- hi  out  XLEN  current HI
- lo  out  XLEN  current LO

Behaviour:
- Reset: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `req_ready`=1, counter=0.
- States:
  - IDLE: `req_ready`=1. `req_valid` latches operands and op at the edge, then goes to CALC with counter=0.
  - CALC: XLEN cycles, one partial step each; the counter increments and the last step (counter=XLEN-1) goes to FIX.
  - FIX: 1 cycle of sign correction. HI/LO are written at the end of FIX. Next state is IDLE with `done`=1 for that cycle.
- Latency: acceptance edge T; HI/LO registers are updated at edge T+XLEN+1; `done` and the new values are visible in the cycle after that edge.
- `busy`=1 in CALC and FIX only. `req_ready`=!busy.
- Back-to-back ops: a new request may be accepted in the `done` cycle.
- Signed ops work on magnitudes:
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned ops skip the fix.
- Multiply result: HI = product[2*XLEN-1:XLEN], LO = product[XLEN-1:0].
- Divide result: LO = quotient, HI = remainder.
- Divide by zero (both signednesses): LO = all ones, HI = req_a.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO:
  - `hi_we`/`lo_we` take effect at the edge only when not busy.
  - If asserted while busy they are ignored; the pipeline is required to stall.
  - In the `done` cycle, a write overrides that register; the other register keeps the op result.
  - `req_valid` together with `hi_we` in IDLE: the write lands, the op starts, and the op result later overwrites both registers.
- Flush:
  - During CALC/FIX it returns to IDLE next edge, HI/LO unchanged, no `done`.
  - A flush in IDLE blocks acceptance of a same-cycle `req_valid`.
  - A flush in FIX wins over the write.
- Reset mid-operation: abort and apply reset values; HI/LO are cleared.
- Request held while busy: ignored. The requester holds `req_valid` until `req_ready`.

Optional Feature:
- MULDIV_FASTZERO_EN: when defined, a request with req_a==0 or req_b==0 skips CALC and goes IDLE→FIX directly.
  - Latency drops to 2 edges: `done` is visible after edge T+2.
  - Results still follow the rules above (multiply by 0 → HI=LO=0; divide by zero → LO=all ones, HI=req_a; 0/x → HI=LO=0).
- Undefined: every op takes the full XLEN-cycle CALC.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 33 edges `done`=1, HI=0xFFFFFFFE, LO=0x00000001; `busy` high exactly 33 cycles.
- MULT a=-7 (0xFFFFFFF9) b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=-7 b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100 b=0 → LO=0xFFFFFFFF, HI=100. DIV a=0x80000000 b=0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIVU 100/7, assert `flush` at CALC cycle 10 → IDLE next cycle, HI/LO keep prior values (e.g. both 0x12345678), no `done` pulse.
- Busy with MULTU 3×5, pulse `hi_we`=1 data 0xAAAA → ignored; after `done`: HI=0, LO=15. In the `done` cycle issue `lo_we` 0x55 plus a new `req_valid` → LO=0x55 next cycle, new op accepted.
- MULDIV_FASTZERO_EN defined: MULT a=0 b=9 → `done` visible after 2 edges, HI=LO=0. Undefined: same request takes 33 edges.
